match_monitor: RTL

Downstream consumer of the pipelined E/F compare stage. Samples the 1-bit equality flag and the E/F bytes over a fixed window of cycles. Accumulates match statistics and captures the first mismatch. Presents a single summary record on a valid/ready handshake, which the bring-up logic or debug readout drains.

---
 rtl/match_mon_pkg.sv | 18 +
 rtl/match_monitor_run_tracker.sv | 36 +++
 rtl/match_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/match_mon_pkg.sv
// match_mon_pkg: shared FSM states, default sizing and the report record layout
package match_mon_pkg;
  localparam int DEF_WINDOW = 256;
  localparam int DEF_CNT_W  = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;
  typedef struct packed {
    logic [DEF_CNT_W-1:0] match_cnt;
    logic [DEF_CNT_W-1:0] max_run;
    logic                 any_mm;
    logic [DEF_CNT_W-1:0] mm_idx;
    logic [7:0]           mm_e;
    logic [7:0]           mm_f;
  } rpt_t;
endpackage

// File: rtl/match_monitor_run_tracker.sv
// run_tracker: saturating current/longest run of hits
//   clk, rst         clock and synchronous active-high reset
//   clr_i            zero both counters (wins over en_i)
//   en_i, hit_i      sample strobe and hit flag
//   max_o            registered longest run
//   max_nxt_o        longest run including the sample being taken this cycle
module run_tracker import match_mon_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             hit_i,
  output logic [CNT_W-1:0] max_o,
  output logic [CNT_W-1:0] max_nxt_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] run_q, run_d, max_q, max_d, run_inc;
  always_comb begin
    run_inc = (run_q == '1) ? run_q : run_q + ONE;
    run_d   = clr_i ? '0 : !en_i ? run_q : hit_i ? run_inc : '0;
    max_d   = clr_i ? '0 : (en_i && hit_i && run_inc > max_q) ? run_inc : max_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      max_q <= '0;
    end else begin
      run_q <= run_d;
      max_q <= max_d;
    end
  end
  assign max_o     = max_q;
  assign max_nxt_o = max_d;
endmodule

// File: rtl/match_monitor.sv
// match_monitor: windowed match statistics and first-mismatch capture for the E/F compare stage
//   clk, rst              clock and synchronous active-high reset
//   start                 begin a window (honoured only when idle)
//   match_in              compare flag, one cycle behind e_in/f_in
//   e_in, f_in            compare stage operands
//   busy                  measuring or holding a report
//   rpt_valid/rpt_ready   summary record handshake
//   rpt_*                 summary of the last completed window
module match_monitor import match_mon_pkg::*; #(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             match_in,
  input  logic [7:0]       e_in,
  input  logic [7:0]       f_in,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_match_cnt,
  output logic [CNT_W-1:0] rpt_max_run,
  output logic             rpt_any_mm,
  output logic [CNT_W-1:0] rpt_mm_idx,
  output logic [7:0]       rpt_mm_e,
  output logic [7:0]       rpt_mm_f
);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  typedef struct packed {
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] max_run;
    logic             any_mm;
    logic [CNT_W-1:0] mm_idx;
    logic [7:0]       mm_e;
    logic [7:0]       mm_f;
  } report_t;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, match_q, match_d, mm_idx_q, mm_idx_d;
  logic             any_mm_q, any_mm_d;
  logic [7:0]       e_dly_q, f_dly_q, mm_e_q, mm_e_d, mm_f_q, mm_f_d;
  report_t          rpt_q, rpt_d;
  logic             trk_clr, trk_en;
  logic [CNT_W-1:0] max_run, max_run_nxt;
  run_tracker #(.CNT_W(CNT_W)) u_run (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (trk_clr),
    .en_i      (trk_en),
    .hit_i     (match_in),
    .max_o     (max_run),
    .max_nxt_o (max_run_nxt)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    match_d  = match_q;
    any_mm_d = any_mm_q;
    mm_idx_d = mm_idx_q;
    mm_e_d   = mm_e_q;
    mm_f_d   = mm_f_q;
    rpt_d    = rpt_q;
    trk_clr  = 1'b0;
    trk_en   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = MEASURE;
        idx_d    = '0;
        match_d  = '0;
        any_mm_d = 1'b0;
        mm_idx_d = '0;
        mm_e_d   = '0;
        mm_f_d   = '0;
        trk_clr  = 1'b1;
      end
      MEASURE: begin
        trk_en = 1'b1;
        idx_d  = (idx_q == '1) ? idx_q : idx_q + ONE;
        if (match_in)
          match_d = (match_q == '1) ? match_q : match_q + ONE;
        else if (!any_mm_q) begin
          // match_in judges last cycle's operands, so capture the delayed copies
          any_mm_d = 1'b1;
          mm_idx_d = idx_q;
          mm_e_d   = e_dly_q;
          mm_f_d   = f_dly_q;
        end
        if (idx_q == LAST) begin
          // fold the final sample in now so the record is complete when rpt_valid rises
          state_d = REPORT;
          rpt_d   = '{match_cnt: match_d, max_run: max_run_nxt, any_mm: any_mm_d,
                      mm_idx: mm_idx_d, mm_e: mm_e_d, mm_f: mm_f_d};
        end
      end
      REPORT: if (rpt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      match_q  <= '0;
      any_mm_q <= 1'b0;
      mm_idx_q <= '0;
      mm_e_q   <= '0;
      mm_f_q   <= '0;
      e_dly_q  <= '0;
      f_dly_q  <= '0;
      rpt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      match_q  <= match_d;
      any_mm_q <= any_mm_d;
      mm_idx_q <= mm_idx_d;
      mm_e_q   <= mm_e_d;
      mm_f_q   <= mm_f_d;
      e_dly_q  <= e_in;
      f_dly_q  <= f_in;
      rpt_q    <= rpt_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign rpt_valid     = state_q == REPORT;
  assign rpt_match_cnt = rpt_q.match_cnt;
  assign rpt_max_run   = rpt_q.max_run;
  assign rpt_any_mm    = rpt_q.any_mm;
  assign rpt_mm_idx    = rpt_q.mm_idx;
  assign rpt_mm_e      = rpt_q.mm_e;
  assign rpt_mm_f      = rpt_q.mm_f;
endmodule
